// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline stage register with a
// 2-entry skid buffer (main entry M drives the outputs, skid entry S absorbs
// one beat of backpressure) so that in_ready comes straight from a flop.
// Supports a synchronous flush and forces the control bus to CTRL_BUBBLE
// whenever no valid beat is presented.
// Optional build macro: PIPE_STAGE_REG_STATS_EN adds stall/bubble counters.
module pipe_stage_reg #(
    parameter int unsigned         DATA_W      = 32,
    parameter int unsigned         CTRL_W      = 8,
    parameter logic [CTRL_W-1:0]   CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_REG_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0]   s_data_q, s_data_d;
    logic [CTRL_W-1:0]   s_ctrl_q, s_ctrl_d;
    logic                in_ready_q;

    // Next-state and entry-load decisions; flush overrides every other event
    // and simply leaves the entry contents in place (they are invalid anyway,
    // and out_data is meant to hold its last value).
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        m_data_d = in_data;
                        m_ctrl_d = in_ctrl;
                        state_d  = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (out_ready && in_valid) begin
                        // Enqueue and dequeue together: refill M directly,
                        // never touching S.
                        m_data_d = in_data;
                        m_ctrl_d = in_ctrl;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end else if (in_valid) begin
                        s_data_d = in_data;
                        s_ctrl_d = in_ctrl;
                        state_d  = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so the input side is ignored.
                    if (out_ready) begin
                        m_data_d = s_data_q;
                        m_ctrl_d = s_ctrl_q;
                        state_d  = ST_BUSY;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and entry registers; in_ready is precomputed from the next state
    // so it never depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            m_data_q   <= '0;
            m_ctrl_q   <= '0;
            s_data_q   <= '0;
            s_ctrl_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            m_data_q   <= m_data_d;
            m_ctrl_q   <= m_ctrl_d;
            s_data_q   <= s_data_d;
            s_ctrl_q   <= s_ctrl_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // Output decode from the registered state.
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = (state_q != ST_EMPTY);
        out_data  = m_data_q;
        out_ctrl  = (state_q != ST_EMPTY) ? m_ctrl_q : CTRL_BUBBLE;
        case (state_q)
            ST_BUSY: occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

`ifdef PIPE_STAGE_REG_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    // Performance counters: wrap naturally, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (!out_valid && !flush) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + short random bench for pipe_stage_reg with a scoreboard queue.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_REG_STATS_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
    logic [31:0]       exp_stall;
    logic [31:0]       exp_bubble;
`endif

    int checks = 0;
    int errors = 0;

    logic [DATA_W+CTRL_W-1:0] sb[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_REG_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare the presented state against the model, then clock one edge and
    // advance the model. Called with inputs already driven, between edges.
    task automatic tick(input string tag);
        logic exp_in_ready;
        logic exp_out_valid;
        logic out_fire;
        logic in_fire;
        #1;
        exp_in_ready  = (sb.size() < 2);
        exp_out_valid = (sb.size() > 0);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(exp_out_valid));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(exp_in_ready));
        chk({tag, ".occupancy"}, 64'(occupancy), 64'(sb.size()));
        if (exp_out_valid) begin
            chk({tag, ".out_data"}, 64'(out_data), 64'(sb[0][DATA_W+CTRL_W-1:CTRL_W]));
            chk({tag, ".out_ctrl"}, 64'(out_ctrl), 64'(sb[0][CTRL_W-1:0]));
        end else begin
            chk({tag, ".bubble_ctrl"}, 64'(out_ctrl), 64'(0));
        end
`ifdef PIPE_STAGE_REG_STATS_EN
        chk({tag, ".stall_cnt"},  64'(stall_cnt),  64'(exp_stall));
        chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(exp_bubble));
        if (rst) begin
            exp_stall  = 0;
            exp_bubble = 0;
        end else begin
            if (exp_out_valid && !out_ready) exp_stall++;
            if (!exp_out_valid && !flush)   exp_bubble++;
        end
`endif
        out_fire = exp_out_valid && out_ready;
        in_fire  = exp_in_ready && in_valid;
        $display("%s: in_v=%0b in_d=%h out_r=%0b flush=%0b rst=%0b occ=%0d out_v=%0b out_d=%h",
                 tag, in_valid, in_data, out_ready, flush, rst, occupancy, out_valid, out_data);
        if (rst) begin
            sb.delete();
        end else begin
            if (out_fire) void'(sb.pop_front());
            if (flush) sb.delete();
            else if (in_fire) sb.push_back({in_data, in_ctrl});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                         input logic [CTRL_W-1:0] c, input logic r);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
`ifdef PIPE_STAGE_REG_STATS_EN
        exp_stall = 0; exp_bubble = 0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1. reset / idle
        #1 chk("reset.out_data", 64'(out_data), 64'(0));
        tick("idle0");
        tick("idle1");

        // 2. streaming with out_ready=1
        drive(1'b1, 32'h11, 8'h05, 1'b1); tick("stream11");
        chk("lat11", 64'(out_data), 64'h11);
        drive(1'b1, 32'h22, 8'h05, 1'b1); tick("stream22");
        chk("lat22", 64'(out_data), 64'h22);
        drive(1'b1, 32'h33, 8'h05, 1'b1); tick("stream33");
        chk("lat33", 64'(out_data), 64'h33);
        drive(1'b0, 32'hDEAD, 8'hFF, 1'b1); tick("stream_drain");
        tick("stream_empty");

        // 3. backpressure
        drive(1'b1, 32'hA0, 8'h11, 1'b0); tick("bp_a0");
        drive(1'b1, 32'hA1, 8'h12, 1'b0); tick("bp_a1");
        drive(1'b1, 32'hA2, 8'h13, 1'b0); tick("bp_a2_held");
        chk("bp.full_occ", 64'(occupancy), 64'd2);
        chk("bp.full_head", 64'(out_data), 64'hA0);
        drive(1'b1, 32'hA2, 8'h13, 1'b1); tick("bp_rel0");
        drive(1'b1, 32'hA2, 8'h13, 1'b1); tick("bp_rel1");
        drive(1'b0, 32'h0, 8'h0, 1'b1);   tick("bp_rel2");
        tick("bp_empty");

        // 4. flush in FULL with a simultaneous input beat
        drive(1'b1, 32'hC0, 8'h21, 1'b0); tick("fl_c0");
        drive(1'b1, 32'hC1, 8'h22, 1'b0); tick("fl_c1");
        drive(1'b1, 32'hBB, 8'h33, 1'b0); flush = 1'b1; tick("fl_flush");
        flush = 1'b0;
        drive(1'b0, 32'h0, 8'h0, 1'b1); tick("fl_after");
        tick("fl_after2");
        // flush in BUSY with an output handshake on the same edge
        drive(1'b1, 32'hD0, 8'h44, 1'b1); tick("fl_d0");
        drive(1'b1, 32'hD1, 8'h45, 1'b1); flush = 1'b1; tick("fl_busy");
        flush = 1'b0;
        drive(1'b0, 32'h0, 8'h0, 1'b1); tick("fl_busy_after");

        // 5. reset mid-operation in FULL, then flush+reset together
        drive(1'b1, 32'hE0, 8'h51, 1'b0); tick("rs_e0");
        drive(1'b1, 32'hE1, 8'h52, 1'b0); tick("rs_e1");
        rst = 1'b1; tick("rs_assert");
        rst = 1'b0;
        chk("rs.out_data", 64'(out_data), 64'(0));
        drive(1'b0, 32'h0, 8'h0, 1'b0); tick("rs_idle");
        drive(1'b1, 32'hF0, 8'h61, 1'b0); tick("rs_f0");
        rst = 1'b1; flush = 1'b1; tick("rs_flush_rst");
        rst = 1'b0; flush = 1'b0;
        chk("rsfl.out_data", 64'(out_data), 64'(0));
        drive(1'b0, 32'h0, 8'h0, 1'b0); tick("rsfl_idle");

`ifdef PIPE_STAGE_REG_STATS_EN
        // 6. stats: stage already holding a beat, 4 stalled valid cycles
        drive(1'b1, 32'h71, 8'h01, 1'b0); tick("st_fill");
        begin
            logic [31:0] s0;
            s0 = exp_stall;
            for (int i = 0; i < 4; i++) begin
                drive(1'b1, 32'h72 + i, 8'h02, 1'b0); tick("st_stall");
            end
            chk("stats.stall4", 64'(stall_cnt - s0), 64'd4);
        end
        drive(1'b0, 32'h0, 8'h0, 1'b1); tick("st_drain0");
        tick("st_drain1");
        begin
            logic [31:0] b0;
            b0 = bubble_cnt;
            for (int i = 0; i < 3; i++) begin
                tick("st_idle");
            end
            chk("stats.bubble3", 64'(bubble_cnt - b0 >= 3), 64'd1);
        end
        flush = 1'b1; tick("st_flush");
        flush = 1'b0; tick("st_after_flush");
        chk("stats.flush_keeps", 64'(stall_cnt != 0), 64'd1);
`endif

        // random mix
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 8'($urandom),
                  ($urandom_range(0, 3) != 0));
            flush = ($urandom_range(0, 19) == 0);
            tick("rnd");
        end
        flush = 1'b0;

        // bounded drain: every accepted beat must come out
        drive(1'b0, 32'h0, 8'h0, 1'b1);
        for (int i = 0; i < 8 && sb.size() > 0; i++) tick("drain");
        chk("drain.sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
